// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
// Shares one byte-wide SPI serializer among NREQ byte producers. A pending
// request is arbitrated in IDLE, loaded into the serializer in LOAD, and the
// scheduler then sits in WAIT until the serializer reports completion. A
// watchdog aborts a transfer that never completes. GAP inserts idle cycles
// before the next byte is served.
//
// Build option: define SPI_SCHED_PRIORITY_EN for fixed priority, where the
// lowest asserted req index always wins and no round-robin pointer exists.
// Without it, arbitration is round-robin starting at the slot after the last
// winner.
//
// Handshake: a requester raises req[i] with its byte on data[8i+7:8i] and
// holds both stable until its one-cycle grant[i]; grant coincides with
// ser_load. It may present the next byte the cycle after grant. ser_done is a
// completion strobe from the serializer, honoured only in WAIT.
module spi_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       data,
  output logic [NREQ-1:0]         grant,
  output logic [7:0]              ser_data,
  output logic                    ser_load,
  input  logic                    ser_done,
  output logic                    ser_abort,
  output logic [$clog2(NREQ)-1:0] chan,
  output logic                    busy,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  localparam int CHW  = $clog2(NREQ);
  localparam int MAXC = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic [CW-1:0]   gap_cnt_q, gap_cnt_d, gap_inc;
  logic [7:0]      byte_q, byte_d;
  logic [CHW-1:0]  chan_q, chan_d;

  logic [NREQ-1:0] cand;
  logic            win_found;
  logic [CHW-1:0]  win_idx;
  logic [7:0]      win_byte;
  logic            tmo_reached;
  logic            tmo_hit;

`ifdef SPI_SCHED_PRIORITY_EN
  // Fixed priority: every asserted request is a candidate, lowest index wins.
  assign cand = req;
`else
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] hi_req;

  // Round-robin: prefer requests at or above the pointer; if none, wrap around.
  always_comb begin
    hi_req = '0;
    for (int j = 0; j < NREQ; j++) begin
      hi_req[j] = req[j] && (CHW'(j) >= ptr_q);
    end
  end

  assign cand  = (hi_req != '0) ? hi_req : req;

  // Pointer moves to the slot after the winner once its byte is loaded.
  assign ptr_d = (state_q != LOAD)             ? ptr_q :
                 (chan_q == CHW'(NREQ - 1))    ? '0    :
                                                 chan_q + 1'b1;

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Lowest-index pick among candidates, with the matching byte.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_byte  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = CHW'(i);
        win_byte  = data[8*i +: 8];
      end
    end
  end

  // Counters read as "this is the Nth cycle" so the compare equals the parameter.
  assign wait_inc    = wait_cnt_q + 1'b1;
  assign gap_inc     = gap_cnt_q + 1'b1;
  assign tmo_reached = (wait_inc == CW'(TIMEOUT));
  // Completion in the same cycle as the timeout counts as a normal finish.
  assign tmo_hit     = (state_q == WAIT) && !ser_done && tmo_reached;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including counter and latch updates.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    gap_cnt_d  = '0;
    byte_d     = byte_q;
    chan_d     = chan_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOAD;
          byte_d  = win_byte;
          chan_d  = win_idx;
        end
      end
      LOAD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ser_done || tmo_reached) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      GAP: begin
        if (gap_inc == CW'(GAP_CYCLES)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers: counters, latched byte and owning channel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      byte_q     <= 8'h00;
      chan_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      byte_q     <= byte_d;
      chan_q     <= chan_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    grant     = '0;
    ser_load  = 1'b0;
    busy      = (state_q != IDLE);
    err       = tmo_hit;
    ser_abort = tmo_hit;
    if (state_q == LOAD) begin
      ser_load      = 1'b1;
      grant[chan_q] = 1'b1;
    end
  end

  assign ser_data  = byte_q;
  assign chan      = chan_q;
  assign dbg_state = state_q;

endmodule

// File: doc/spi_tx_scheduler.md
# spi_tx_scheduler

Shares one byte-wide SPI output serializer among several byte producers, such as hash-table output channels. It arbitrates pending byte requests and loads the winning byte into the serializer. It then waits for the serializer's completion pulse and enforces an inter-byte gap before serving the next request. A watchdog aborts a transfer whose completion never arrives.

## Interface
- NREQ, 4: number of requesters; valid range 2..8.
- GAP_CYCLES, 2: idle cycles inserted after each byte; 0 means no gap.
- TIMEOUT, 32: maximum number of WAIT cycles before a transfer is aborted; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester byte-pending flag.
- data  in  8*NREQ  byte for requester i on bits [8i+7:8i].
- grant  out  NREQ  one-hot, one-cycle pulse: requester's byte accepted.
- ser_data  out  8  byte presented to serializer.
- ser_load  out  1  one-cycle pulse: serializer captures ser_data.
- ser_done  in  1  one-cycle pulse from serializer: 8 bits shifted out.
- ser_abort  out  1  one-cycle pulse: serializer must drop the current byte.
- chan  out  $clog2(NREQ)  index of the requester currently owning the serializer.
- busy  out  1  high whenever state ≠ IDLE.
- err  out  1  one-cycle pulse on watchdog timeout.

## Operation
- States: IDLE, LOAD, WAIT, GAP.
- IDLE:
  - If any req bit is set, select a winner w, latch data[w] into the byte register, latch chan=w, and go to LOAD.
  - Otherwise stay in IDLE.
- Winner selection is round-robin. Search starts at pointer ptr and runs upward modulo NREQ. The first set req bit wins.
- ptr ← (w+1) mod NREQ, updated in LOAD.
- LOAD (exactly one cycle):
  - ser_load=1, grant[w]=1, ser_data=latched byte.
  - Next state is WAIT.
- WAIT:
  - On ser_done, go to GAP, or to IDLE when GAP_CYCLES=0.
  - A wait counter increments every WAIT cycle. When it reaches TIMEOUT without ser_done: pulse err and ser_abort, then go to GAP/IDLE as above.
- GAP: counter runs GAP_CYCLES cycles, then go to IDLE.
- ser_data and chan hold their values from LOAD until the next LOAD.
- Requester rules:
  - Hold req and data stable until its grant pulse.
  - It may present the next byte the cycle after grant.
- A req dropped between IDLE selection and LOAD is still granted. This is a protocol violation and carries no special handling.

## Timing
- Reset (rst=0 at a rising edge) forces:
  - state=IDLE, ptr=0, counters=0.
  - grant=0, ser_load=0, ser_abort=0, err=0, busy=0, ser_data=8'h00, chan=0.
- Reset takes precedence over everything, mid-transfer included. The scheduler issues no abort pulse on reset; the serializer shares rst.
- Latency: req seen in IDLE at cycle T gives ser_load and grant in cycle T+1.
- Minimum byte period: 1 (IDLE) + 1 (LOAD) + WAIT length + GAP_CYCLES.
- ser_done and timeout in the same cycle: ser_done wins, with no err and no abort.
- ser_done outside WAIT is ignored, with no state change.
- Timeout fires in the TIMEOUT-th WAIT cycle counted from the cycle after LOAD.
- The wait and gap counters are $clog2(max(TIMEOUT,GAP_CYCLES)+1) bits wide and saturate-free: their terminal compare equals the parameter value.

## Configuration
- SPI_SCHED_PRIORITY_EN:
  - When defined: fixed priority, lowest asserted req index always wins, and ptr is not implemented.
  - When undefined: round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
Bench uses NREQ=4, GAP_CYCLES=2, TIMEOUT=32, and a serializer model that pulses ser_done 16 cycles after ser_load unless stated otherwise.

- Single request: req=4'b0100, data[23:16]=8'hA5 → next cycle ser_load=1, grant=4'b0100, ser_data=8'hA5, chan=2. ser_done 16 cycles later; busy falls 2 cycles after that.
- Round-robin: req=4'b1111 held, each requester re-armed after its grant → grant order 0,1,2,3,0. Exactly one grant per byte period.
- Timeout: model never pulses ser_done → err and ser_abort pulse together 32 cycles after ser_load, then 2 GAP cycles, then IDLE accepts the next req.
- Simultaneous ser_done and timeout: model pulses ser_done in WAIT cycle 32 → no err, no ser_abort, normal GAP.
- Reset mid-WAIT: rst=0 for one edge 5 cycles after ser_load → all outputs 0 the next cycle. A following req=4'b0010 is granted to 1, since ptr was reset to 0.
- With SPI_SCHED_PRIORITY_EN: req=4'b1010 held → requester 1 is granted every byte and requester 3 is never granted.
